// File: rtl/clock_disp_pkg.sv
// -----------------------------------------------------------------------------
// clock_disp_pkg
// Shared constants and helpers for the alarm-clock 7-segment display path.
//   - SEG_0..SEG_9, SEG_BLANK : active-high segment patterns {g,f,e,d,c,b,a}
//   - IDX_S0..IDX_H1          : scan slot index of each digit (slot 0 = S_dig0)
//   - DP_MASK                 : slots whose decimal point is lit (HH.MM.SS)
//   - digits_t                : snapshot of the six time digits
// -----------------------------------------------------------------------------
package clock_disp_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [2:0] IDX_S0 = 3'd0;
   localparam logic [2:0] IDX_S1 = 3'd1;
   localparam logic [2:0] IDX_M0 = 3'd2;
   localparam logic [2:0] IDX_M1 = 3'd3;
   localparam logic [2:0] IDX_H0 = 3'd4;
   localparam logic [2:0] IDX_H1 = 3'd5;

   // Decimal point sits after the hour units and the minute units digit.
   localparam logic [5:0] DP_MASK = 6'b010100;
   localparam logic [5:0] AN_NONE = 6'b000000;

   typedef struct packed {
      logic [1:0] h1;
      logic [3:0] h0;
      logic [3:0] m1;
      logic [3:0] m0;
      logic [3:0] s1;
      logic [3:0] s0;
   } digits_t;

   localparam digits_t DIGITS_ZERO = '{h1: 2'd0, h0: 4'd0, m1: 4'd0,
                                       m0: 4'd0, s1: 4'd0, s0: 4'd0};

   // One-hot digit enable for a scan slot; unused codes 6/7 select nothing.
   function automatic logic [5:0] idx_onehot(input logic [2:0] idx);
      logic [5:0] v;
      case (idx)
         IDX_S0:  v = 6'b000001;
         IDX_S1:  v = 6'b000010;
         IDX_M0:  v = 6'b000100;
         IDX_M1:  v = 6'b001000;
         IDX_H0:  v = 6'b010000;
         IDX_H1:  v = 6'b100000;
         default: v = AN_NONE;
      endcase
      return v;
   endfunction

   // Decimal point state for a scan slot, taken from DP_MASK without indexing.
   function automatic logic dp_lit(input logic [2:0] idx);
      return |(DP_MASK & idx_onehot(idx));
   endfunction

endpackage

// File: rtl/clock_display_mux_bcd_to_7seg.sv
// -----------------------------------------------------------------------------
// bcd_to_7seg
// Combinational BCD to 7-segment decoder, active-high pattern {g,f,e,d,c,b,a}.
// Codes 10..15 decode to a blank digit; no error is flagged.
// Ports:
//   i_bcd  in  4  BCD digit
//   o_seg  out 7  segment pattern, 1 = segment lit
// -----------------------------------------------------------------------------
module bcd_to_7seg
   import clock_disp_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   // Digit decode table.
   always_comb begin
      o_seg = SEG_BLANK;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/clock_display_mux.sv
// -----------------------------------------------------------------------------
// clock_display_mux
// Drives a 6-digit multiplexed 7-segment display from the alarm clock's BCD
// time digits. The six digits are snapshotted once per frame so a frame never
// mixes old and new time, each slot starts with one blanked clock to stop
// ghosting, and the whole display flashes while Alarm is high.
// Parameters:
//   SCAN_DIV     clocks per digit slot (>=2)
//   BLINK_FRAMES frames per blink half-period while Alarm=1 (>=1)
//   ACTIVE_LOW   1: seg/dp/an driven active-low, 0: active-high
//   LZ_SUPPRESS  1: blank the hour tens digit when it is 0
// Ports:
//   clock        in   1  system clock, rising edge
//   reset        in   1  asynchronous reset, active low
//   H_dig1       in   2  hour tens digit
//   H_dig0       in   4  hour units digit
//   M_dig1       in   4  minute tens digit
//   M_dig0       in   4  minute units digit
//   S_dig1       in   4  second tens digit
//   S_dig0       in   4  second units digit
//   Alarm        in   1  alarm ringing, level sensitive
//   seg          out  7  segments {g,f,e,d,c,b,a}
//   dp           out  1  decimal point
//   an           out  6  digit enables, bit0 = S_dig0 .. bit5 = H_dig1
//   frame_done   out  1  one-clock pulse when a new snapshot is taken
// -----------------------------------------------------------------------------
module clock_display_mux
   import clock_disp_pkg::*;
#(
   parameter int SCAN_DIV     = 4,
   parameter int BLINK_FRAMES = 4,
   parameter bit ACTIVE_LOW   = 1'b1,
   parameter bit LZ_SUPPRESS  = 1'b1
)(
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] H_dig1,
   input  logic [3:0] H_dig0,
   input  logic [3:0] M_dig1,
   input  logic [3:0] M_dig0,
   input  logic [3:0] S_dig1,
   input  logic [3:0] S_dig0,
   input  logic       Alarm,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an,
   output logic       frame_done
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [BF_W-1:0]  BF_MAX   = BF_W'(BLINK_FRAMES - 1);
   localparam logic [BF_W-1:0]  BF_ZERO  = {BF_W{1'b0}};
   localparam logic [BF_W-1:0]  BF_ONE   = BF_W'(1);

   // State registers
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   digits_t          r_shadow;
   logic             r_blink_on;
   logic [BF_W-1:0]  r_bframe;

   // Output registers
   logic [6:0]       r_seg;
   logic             r_dp;
   logic [5:0]       r_an;
   logic             r_frame_done;

   // Next-state and output-pattern wires
   logic             w_tick;
   logic             w_frame_end;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [2:0]       w_idx_nxt;
   digits_t          w_inputs;
   digits_t          w_shadow_nxt;
   logic             w_blink_nxt;
   logic [BF_W-1:0]  w_bframe_nxt;
   logic [3:0]       w_dig_sel;
   logic [6:0]       w_dec;
   logic [6:0]       w_seg_pat;
   logic [5:0]       w_an_pat;
   logic             w_dp_pat;

   assign w_inputs = '{h1: H_dig1, h0: H_dig0, m1: M_dig1,
                       m0: M_dig0, s1: S_dig1, s0: S_dig0};

   // Prescaler, scan index and frame snapshot next-state.
   always_comb begin
      w_tick       = (r_cnt == CNT_MAX);
      w_frame_end  = w_tick && (r_idx == IDX_H1);
      w_cnt_nxt    = r_cnt;
      w_idx_nxt    = r_idx;
      w_shadow_nxt = r_shadow;
      if (w_tick) begin
         w_cnt_nxt = CNT_ZERO;
         if (r_idx == IDX_H1) begin
            w_idx_nxt = IDX_S0;
         end else begin
            w_idx_nxt = r_idx + 3'd1;
         end
      end else begin
         w_cnt_nxt = r_cnt + CNT_ONE;
         w_idx_nxt = r_idx;
      end
      // Snapshot coincides with the wrap to slot 0, so slot 0 already shows it.
      if (w_frame_end) begin
         w_shadow_nxt = w_inputs;
      end else begin
         w_shadow_nxt = r_shadow;
      end
   end

   // Blink half-period counter; dropping Alarm restores a visible display at once.
   always_comb begin
      w_blink_nxt  = r_blink_on;
      w_bframe_nxt = r_bframe;
      if (!Alarm) begin
         w_blink_nxt  = 1'b1;
         w_bframe_nxt = BF_ZERO;
      end else if (w_frame_end) begin
         if (r_bframe == BF_MAX) begin
            w_bframe_nxt = BF_ZERO;
            w_blink_nxt  = ~r_blink_on;
         end else begin
            w_bframe_nxt = r_bframe + BF_ONE;
            w_blink_nxt  = r_blink_on;
         end
      end else begin
         w_blink_nxt  = r_blink_on;
         w_bframe_nxt = r_bframe;
      end
   end

   // Digit selected for the slot about to be shown.
   always_comb begin
      w_dig_sel = 4'hF;
      case (w_idx_nxt)
         IDX_S0:  w_dig_sel = w_shadow_nxt.s0;
         IDX_S1:  w_dig_sel = w_shadow_nxt.s1;
         IDX_M0:  w_dig_sel = w_shadow_nxt.m0;
         IDX_M1:  w_dig_sel = w_shadow_nxt.m1;
         IDX_H0:  w_dig_sel = w_shadow_nxt.h0;
         IDX_H1:  w_dig_sel = {2'b00, w_shadow_nxt.h1};
         default: w_dig_sel = 4'hF;
      endcase
   end

   bcd_to_7seg u_dec (
      .i_bcd (w_dig_sel),
      .o_seg (w_dec)
   );

   // Active-high output patterns: leading-zero blank, anti-ghost slot start, blink.
   always_comb begin
      w_seg_pat = w_dec;
      w_an_pat  = AN_NONE;
      w_dp_pat  = dp_lit(w_idx_nxt);
      if (LZ_SUPPRESS && (w_idx_nxt == IDX_H1) && (w_shadow_nxt.h1 == 2'd0)) begin
         w_seg_pat = SEG_BLANK;
      end else begin
         w_seg_pat = w_dec;
      end
      if ((w_cnt_nxt != CNT_ZERO) && w_blink_nxt) begin
         w_an_pat = idx_onehot(w_idx_nxt);
      end else begin
         w_an_pat = AN_NONE;
      end
   end

   // Prescaler, scan index, snapshot and blink state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt      <= CNT_ZERO;
         r_idx      <= IDX_S0;
         r_shadow   <= DIGITS_ZERO;
         r_blink_on <= 1'b1;
         r_bframe   <= BF_ZERO;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_shadow   <= w_shadow_nxt;
         r_blink_on <= w_blink_nxt;
         r_bframe   <= w_bframe_nxt;
      end
   end

   // Output register; pin polarity is applied only here.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_seg        <= {7{ACTIVE_LOW}};
         r_dp         <= ACTIVE_LOW;
         r_an         <= {6{ACTIVE_LOW}};
         r_frame_done <= 1'b0;
      end else begin
         r_seg        <= w_seg_pat ^ {7{ACTIVE_LOW}};
         r_dp         <= w_dp_pat ^ ACTIVE_LOW;
         r_an         <= w_an_pat ^ {6{ACTIVE_LOW}};
         r_frame_done <= w_frame_end;
      end
   end

   assign seg        = r_seg;
   assign dp         = r_dp;
   assign an         = r_an;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_clock_display_mux.sv
module tb_clock_display_mux;

   localparam int SD = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] h1;
   logic [3:0] h0, m1, m0, s1, s0;
   logic       alarm;

   logic [6:0] seg_a, seg_b;
   logic       dp_a, dp_b;
   logic [5:0] an_a, an_b;
   logic       fd_a, fd_b;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clock = ~clock;

   // A: active-high pins, leading-zero blanking, 2-frame blink
   clock_display_mux #(.SCAN_DIV(SD), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b0), .LZ_SUPPRESS(1'b1)) u_dut_a (
      .clock(clock), .reset(reset), .H_dig1(h1), .H_dig0(h0), .M_dig1(m1), .M_dig0(m0),
      .S_dig1(s1), .S_dig0(s0), .Alarm(alarm),
      .seg(seg_a), .dp(dp_a), .an(an_a), .frame_done(fd_a));

   // B: active-low pins, no leading-zero blanking, 4-frame blink
   clock_display_mux #(.SCAN_DIV(SD), .BLINK_FRAMES(4), .ACTIVE_LOW(1'b1), .LZ_SUPPRESS(1'b0)) u_dut_b (
      .clock(clock), .reset(reset), .H_dig1(h1), .H_dig0(h0), .M_dig1(m1), .M_dig0(m0),
      .S_dig1(s1), .S_dig0(s0), .Alarm(alarm),
      .seg(seg_b), .dp(dp_b), .an(an_b), .frame_done(fd_b));

   typedef struct packed {
      logic [1:0]      h1;
      logic [3:0]      h0, m1, m0, s1, s0;
      logic [5:0][6:0] ea;     // expected active-high seg per slot on A, [5]=H1
      logic [6:0]      eb_h1;  // expected H1 pattern on B (no blanking)
   } vec_t;

   vec_t vecs [6];
   vec_t v_zero, v_mid, v_new;

   function automatic vec_t mk(input logic [1:0] a, input logic [3:0] b, c, d, e, f,
                               input logic [5:0][6:0] ea, input logic [6:0] eb);
      vec_t v;
      v.h1 = a; v.h0 = b; v.m1 = c; v.m0 = d; v.s1 = e; v.s0 = f;
      v.ea = ea; v.eb_h1 = eb;
      return v;
   endfunction

   task automatic chk(input string name, input int p, input logic [14:0] act, input logic [14:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s p=%0d actual={fd,dp,an,seg}=%h required=%h", name, p, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic apply(input vec_t v);
      h1 = v.h1; h0 = v.h0; m1 = v.m1; m0 = v.m0; s1 = v.s1; s0 = v.s0;
   endtask

   task automatic wait_fd(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (fd_a === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      n_total++;
      if (seen) n_pass++;
      else $display("FAIL %s frame_done not seen within 40 clocks (actual 0, required 1)", name);
   endtask

   // Checks positions first..23 of a frame; the current negedge is position first.
   task automatic check_frame(input string name, input vec_t v, input int first,
                              input int chg_p, input logic [3:0] chg_val);
      int k, c;
      logic [5:0] an_e;
      logic [6:0] sb;
      logic dp_e, fd_e;
      for (int p = first; p < 24; p++) begin
         if (p != first) @(negedge clock);
         k    = p / SD;
         c    = p % SD;
         an_e = (c == 0) ? 6'b000000 : (6'b000001 << k);
         dp_e = (k == 2) || (k == 4);
         fd_e = (p == 0);
         sb   = (k == 5) ? v.eb_h1 : v.ea[k];
         chk({name, "_a"}, p, {fd_a, dp_a, an_a, seg_a}, {fd_e, dp_e, an_e, v.ea[k]});
         chk({name, "_b"}, p, {fd_b, dp_b, an_b, seg_b}, {fd_e, ~dp_e, ~an_e, ~sb});
         if (p == chg_p) s0 = chg_val;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic a_vis, b_vis;
      reset = 1'b0; alarm = 1'b0;
      h1 = 2'd0; h0 = 4'd0; m1 = 4'd0; m0 = 4'd0; s1 = 4'd0; s0 = 4'd0;

      v_zero  = mk(2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, {7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 7'h3F);
      vecs[0] = mk(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D}, 7'h06);
      vecs[1] = mk(2'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8, {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h7F}, 7'h5B);
      vecs[2] = mk(2'd0, 4'd7, 4'd0, 4'd1, 4'hC, 4'd0, {7'h00, 7'h07, 7'h3F, 7'h06, 7'h00, 7'h3F}, 7'h3F);
      vecs[3] = mk(2'd1, 4'd9, 4'd4, 4'd8, 4'hF, 4'hA, {7'h06, 7'h6F, 7'h66, 7'h7F, 7'h00, 7'h00}, 7'h06);
      vecs[4] = mk(2'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, {7'h5B, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 7'h5B);
      vecs[5] = v_zero;
      v_mid   = mk(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd3, {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h4F}, 7'h06);
      v_new   = mk(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h07}, 7'h06);

      // Reset held from time zero: all pins inactive
      repeat (3) @(negedge clock);
      chk("reset_hold_a", 0, {fd_a, dp_a, an_a, seg_a}, 15'h0000);
      chk("reset_hold_b", 0, {fd_b, dp_b, an_b, seg_b}, {1'b0, 1'b1, 6'h3F, 7'h7F});

      // Reset asserted mid-scan: pins go inactive without a clock edge
      reset = 1'b1;
      repeat (9) @(negedge clock);
      #3 reset = 1'b0;
      #1;
      chk("reset_mid_a", 0, {fd_a, dp_a, an_a, seg_a}, 15'h0000);
      chk("reset_mid_b", 0, {fd_b, dp_b, an_b, seg_b}, {1'b0, 1'b1, 6'h3F, 7'h7F});
      @(negedge clock);
      reset = 1'b1;

      // First frame after release shows 00.00.00, then frame_done
      @(negedge clock);
      check_frame("rst_frame", v_zero, 1, -1, 4'd0);
      @(negedge clock);
      check_frame("rst_frame2", v_zero, 0, -1, 4'd0);

      // Table of stable digit patterns
      for (int i = 0; i < 6; i++) begin
         apply(vecs[i]);
         wait_fd("tbl_fd");
         check_frame($sformatf("vec%0d", i), vecs[i], 0, -1, 4'd0);
      end

      // Mid-frame input change is held back until the next snapshot
      apply(v_mid);
      wait_fd("mid_fd");
      check_frame("midchg", v_mid, 0, 8, 4'd7);
      wait_fd("new_fd");
      check_frame("newsnap", v_new, 0, -1, 4'd0);

      // Blink: A is 2 frames on / 2 off, B is 4 on / 4 off
      wait_fd("blink_start");
      alarm = 1'b1;
      for (int f = 0; f < 7; f++) begin
         @(negedge clock);
         a_vis = (f < 2) || (f == 4) || (f == 5);
         b_vis = (f < 4);
         chk("blink_a", f, {9'h000, an_a}, {9'h000, (a_vis ? 6'b000001 : 6'b000000)});
         chk("blink_b", f, {9'h000, an_b}, {9'h000, (b_vis ? 6'b111110 : 6'b111111)});
         if (f < 6) wait_fd("blink_fd");
      end
      // Still dark at slot 1, then drop Alarm: enables return on the next edge
      repeat (4) @(negedge clock);
      chk("dark_a", 5, {9'h000, an_a}, {9'h000, 6'b000000});
      chk("dark_b", 5, {9'h000, an_b}, {9'h000, 6'b111111});
      alarm = 1'b0;
      @(negedge clock);
      chk("unblink_a", 6, {9'h000, an_a}, {9'h000, 6'b000010});
      chk("unblink_b", 6, {9'h000, an_b}, {9'h000, 6'b111101});
      repeat (3) @(negedge clock);
      chk("unblink2_a", 9, {9'h000, an_a}, {9'h000, 6'b000100});
      chk("unblink2_b", 9, {9'h000, an_b}, {9'h000, 6'b111011});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
